// File: rtl/snake_key_pkg.sv
// Shared types and scan-code constants for the PS2 direction controller.
// Direction encoding, FSM states, key decode and opposite-direction helper.
package snake_key_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXTEND = 8'hE0;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_P      = 8'h4D;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;

    typedef struct packed {
        logic hit;
        logic is_pause;
        dir_t dir;
    } key_t;

    function automatic dir_t opposite_dir(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

    // Extended codes only map the arrow cluster; 4D is pause only as a plain code.
    function automatic key_t decode_key(input logic [7:0] code, input logic ext);
        key_t k;
        k.hit      = 1'b1;
        k.is_pause = 1'b0;
        k.dir      = DIR_UP;
        if (ext) begin
            case (code)
                SC_UP:    k.dir = DIR_UP;
                SC_RIGHT: k.dir = DIR_RIGHT;
                SC_DOWN:  k.dir = DIR_DOWN;
                SC_LEFT:  k.dir = DIR_LEFT;
                default:  k.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_W:    k.dir = DIR_UP;
                SC_D:    k.dir = DIR_RIGHT;
                SC_S:    k.dir = DIR_DOWN;
                SC_A:    k.dir = DIR_LEFT;
                SC_P:    k.is_pause = 1'b1;
                default: k.hit = 1'b0;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// DEPTH x 2-bit synchronous direction FIFO with head and last-written outputs.
// A push while full is accepted only if a pop happens in the same cycle.
module dir_fifo
    import snake_key_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  dir_t din,
    output dir_t head,
    output dir_t last,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    dir_t            mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    dir_t            last_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign last      = last_r;
    assign head      = empty ? DIR_UP : mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DIR_UP;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            last_r   <= DIR_UP;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
                last_r          <= din;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ps2_dir_ctrl.sv
// PS2 scan-code to snake direction controller: prefix FSM, decode, acceptance, FIFO.
// Optional typematic repeat filter enabled by defining PS2_KEY_REPEAT_FILTER_EN.
module ps2_dir_ctrl
    import snake_key_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] code_byte,
    input  logic [1:0] game_dir,
    input  logic       dir_ready,
    output logic       dir_valid,
    output logic [1:0] dir_out,
    output logic       pause_toggle,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    ps2_state_t    state_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          pause_r;
    logic          overflow_r;

    logic make_s;
    logic break_s;
    logic ext_s;
    key_t key_s;
    logic make_ok_s;
    dir_t ref_dir_s;
    logic push_s;
    logic pop_s;
    dir_t fifo_head_s;
    dir_t fifo_last_s;
    logic fifo_full_s;
    logic fifo_empty_s;

    // Classify the strobed byte as make/break and plain/extended from the FSM state.
    always_comb begin
        make_s  = 1'b0;
        break_s = 1'b0;
        ext_s   = 1'b0;
        if (code_valid) begin
            case (state_r)
                IDLE: begin
                    if (code_byte != SC_BREAK && code_byte != SC_EXTEND) begin
                        make_s = 1'b1;
                    end else begin
                        make_s = 1'b0;
                    end
                end
                EXT: begin
                    ext_s = 1'b1;
                    if (code_byte != SC_BREAK) begin
                        make_s = 1'b1;
                    end else begin
                        make_s = 1'b0;
                    end
                end
                BRK: begin
                    break_s = 1'b1;
                end
                EXT_BRK: begin
                    break_s = 1'b1;
                    ext_s   = 1'b1;
                end
                default: begin
                    make_s = 1'b0;
                end
            endcase
        end else begin
            make_s = 1'b0;
        end
    end

    assign key_s = decode_key(code_byte, ext_s);

`ifdef PS2_KEY_REPEAT_FILTER_EN
    logic [4:0] held_r;
    logic [2:0] key_idx_s;

    assign key_idx_s = key_s.is_pause ? 3'd4 : {1'b0, key_s.dir};
    assign make_ok_s = !held_r[key_idx_s];

    // Held-key mask: plain and extended codes of one direction share a bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_r <= 5'd0;
        end else if (make_s && key_s.hit) begin
            held_r[key_idx_s] <= 1'b1;
        end else if (break_s && key_s.hit) begin
            held_r[key_idx_s] <= 1'b0;
        end else begin
            held_r <= held_r;
        end
    end
`else
    assign make_ok_s = 1'b1;
`endif

    // The reference is the newest queued move, so reversals are judged against it.
    assign ref_dir_s = fifo_empty_s ? dir_t'(game_dir) : fifo_last_s;
    assign push_s    = make_s && key_s.hit && !key_s.is_pause && make_ok_s &&
                       (key_s.dir != ref_dir_s) && (key_s.dir != opposite_dir(ref_dir_s));
    assign pop_s     = !fifo_empty_s && dir_ready;

    dir_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (key_s.dir),
        .head  (fifo_head_s),
        .last  (fifo_last_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Prefix FSM with idle timeout, pause pulse and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            tmo_cnt_r  <= {TW{1'b0}};
            pause_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            pause_r <= make_s && key_s.hit && key_s.is_pause && make_ok_s;
            if (push_s && fifo_full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (code_valid) begin
                tmo_cnt_r <= {TW{1'b0}};
                case (state_r)
                    IDLE: begin
                        if (code_byte == SC_BREAK) begin
                            state_r <= BRK;
                        end else if (code_byte == SC_EXTEND) begin
                            state_r <= EXT;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    EXT:     state_r <= (code_byte == SC_BREAK) ? EXT_BRK : IDLE;
                    default: state_r <= IDLE;
                endcase
            end else if (state_r == IDLE) begin
                tmo_cnt_r <= {TW{1'b0}};
            end else if (tmo_cnt_r == TW'(TIMEOUT_CYC - 1)) begin
                state_r   <= IDLE;
                tmo_cnt_r <= {TW{1'b0}};
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
        end
    end

    assign dir_valid    = !fifo_empty_s;
    assign dir_out      = fifo_head_s;
    assign pause_toggle = pause_r;
    assign overflow     = overflow_r;

endmodule
